// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter
//   Round-robin arbiter sharing one SRAM port between three requesters:
//   LD (SRAM -> register file load), ST (register -> SRAM store) and
//   BS (APB read buffer -> SRAM store). One transfer is in flight at a
//   time. Loaded words are written back through a dedicated register-file
//   write port. Every output is driven straight from a flop.
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   ld_req/addr/dest, ld_ack     load requester (req held until ack)
//   st_req/addr/data, st_ack     register-store requester
//   bs_req/addr/data, bs_ack     buffer-store requester
//   sram_read_enable, sram_write_enable, sram_address,
//   sram_write_data, sram_read_data   SRAM port
//   reg_w_en/sel/data            register-file write port
//   busy                         high whenever the FSM is not IDLE
module sram_port_arbiter #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 32,
    parameter int REG_W    = 4,
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_req,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [REG_W-1:0]  ld_dest,
    output logic              ld_ack,
    input  logic              st_req,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [DATA_W-1:0] st_data,
    output logic              st_ack,
    input  logic              bs_req,
    input  logic [ADDR_W-1:0] bs_addr,
    input  logic [DATA_W-1:0] bs_data,
    output logic              bs_ack,
    output logic              sram_read_enable,
    output logic              sram_write_enable,
    output logic [ADDR_W-1:0] sram_address,
    output logic [DATA_W-1:0] sram_write_data,
    input  logic [DATA_W-1:0] sram_read_data,
    output logic              reg_w_en,
    output logic [REG_W-1:0]  reg_w_sel,
    output logic [DATA_W-1:0] reg_w_data,
    output logic              busy
);

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_WB} state_t;

    localparam logic [1:0] P_LD = 2'd0;
    localparam logic [1:0] P_ST = 2'd1;
    localparam logic [1:0] P_BS = 2'd2;
    localparam logic [2:0] LAST_RD = 3'(READ_LAT - 1);

    state_t            state_q, state_d;
    logic [1:0]        ptr_q, ptr_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [REG_W-1:0]  dest_q, dest_d;

    logic              ld_ack_q, ld_ack_d, st_ack_q, st_ack_d, bs_ack_q, bs_ack_d;
    logic              re_q, re_d, we_q, we_d, wen_q, wen_d, busy_q, busy_d;
    logic [ADDR_W-1:0] saddr_q, saddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
    logic [REG_W-1:0]  wsel_q, wsel_d;

    // Rotating priority: the first requester at or after ptr_q wins.
    logic [2:0] req_v;
    logic [1:0] gnt;
    logic       gnt_vld;

    assign req_v = {bs_req, st_req, ld_req};

    always_comb begin
        int idx;
        gnt     = ptr_q;
        gnt_vld = 1'b0;
        idx     = 0;
        // Scan from farthest to nearest so the nearest hit overwrites.
        for (int k = 2; k >= 0; k--) begin
            idx = int'(ptr_q) + k;
            if (idx >= 3) idx = idx - 3;
            if (req_v[idx]) begin
                gnt     = 2'(idx);
                gnt_vld = 1'b1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        dest_d   = dest_q;
        ld_ack_d = 1'b0;
        st_ack_d = 1'b0;
        bs_ack_d = 1'b0;
        re_d     = 1'b0;
        we_d     = 1'b0;
        wen_d    = 1'b0;
        saddr_d  = '0;
        wdata_d  = '0;
        rdata_d  = '0;
        wsel_d   = '0;
        case (state_q)
            S_IDLE: begin
                if (gnt_vld) begin
                    ptr_d = (gnt == P_BS) ? P_LD : gnt + 2'd1;
                    case (gnt)
                        P_LD: begin
                            state_d  = S_READ;
                            cnt_d    = '0;
                            addr_d   = ld_addr;
                            dest_d   = ld_dest;
                            ld_ack_d = 1'b1;
                            re_d     = 1'b1;
                            saddr_d  = ld_addr;
                        end
                        P_ST: begin
                            state_d  = S_WRITE;
                            st_ack_d = 1'b1;
                            we_d     = 1'b1;
                            saddr_d  = st_addr;
                            wdata_d  = st_data;
                        end
                        default: begin
                            state_d  = S_WRITE;
                            bs_ack_d = 1'b1;
                            we_d     = 1'b1;
                            saddr_d  = bs_addr;
                            wdata_d  = bs_data;
                        end
                    endcase
                end
            end
            S_WRITE: state_d = S_IDLE;
            S_READ: begin
                if (cnt_q == LAST_RD) begin
                    // Final read cycle: the word on sram_read_data is taken now.
                    state_d = S_WB;
                    wen_d   = 1'b1;
                    wsel_d  = dest_q;
                    rdata_d = sram_read_data;
                end else begin
                    cnt_d   = cnt_q + 3'd1;
                    re_d    = 1'b1;
                    saddr_d = addr_q;
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            ptr_q    <= P_LD;
            cnt_q    <= '0;
            addr_q   <= '0;
            dest_q   <= '0;
            ld_ack_q <= 1'b0;
            st_ack_q <= 1'b0;
            bs_ack_q <= 1'b0;
            re_q     <= 1'b0;
            we_q     <= 1'b0;
            wen_q    <= 1'b0;
            busy_q   <= 1'b0;
            saddr_q  <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            wsel_q   <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            dest_q   <= dest_d;
            ld_ack_q <= ld_ack_d;
            st_ack_q <= st_ack_d;
            bs_ack_q <= bs_ack_d;
            re_q     <= re_d;
            we_q     <= we_d;
            wen_q    <= wen_d;
            busy_q   <= busy_d;
            saddr_q  <= saddr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            wsel_q   <= wsel_d;
        end
    end

    assign ld_ack            = ld_ack_q;
    assign st_ack            = st_ack_q;
    assign bs_ack            = bs_ack_q;
    assign sram_read_enable  = re_q;
    assign sram_write_enable = we_q;
    assign sram_address      = saddr_q;
    assign sram_write_data   = wdata_q;
    assign reg_w_en          = wen_q;
    assign reg_w_sel         = wsel_q;
    assign reg_w_data        = rdata_q;
    assign busy              = busy_q;

endmodule
